// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and FSM state type for the sequential CLA adder
package cla_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] p, g;
    logic [4:0] c;
    assign p = a ^ b;
    assign g = a & b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/cla_seq_add_ctrl.sv
// cla_seq_add_ctrl: multi-cycle add/subtract reusing one 4-bit CLA slice per nibble
module cla_seq_add_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH % SLICE_W != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("cla_seq_add_ctrl: WIDTH must be a positive multiple of 4");
    end

    state_t             state;
    logic [IW-1:0]      idx;
    logic               carry;
    logic [WIDTH-1:0]   opa, opb;
    logic [SLICE_W-1:0] s_sum;
    logic               s_cout;
    logic               last;

    cla4_slice u_slice (
        .a    (opa[SLICE_W*idx +: SLICE_W]),
        .b    (opb[SLICE_W*idx +: SLICE_W]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    assign last      = idx == IW'(NSLICE - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    // FSM: accept operands, add one nibble per CALC cycle, hold result until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opa   <= a;
                    opb   <= op_sub ? ~b : b;
                    carry <= op_sub | cin;
                    idx   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    sum[SLICE_W*idx +: SLICE_W] <= s_sum;
                    carry <= s_cout;
                    idx   <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        cout  <= s_cout;
                        ovf   <= (opa[WIDTH-1] == opb[WIDTH-1]) && (s_sum[SLICE_W-1] != opa[WIDTH-1]);
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// tb_cla_seq_add_ctrl: directed self-checking bench for the sequential CLA adder
module tb_cla_seq_add_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout, ovf, busy;
    logic [15:0] a, b, sum;
    int          n_cmp = 0;
    int          n_err = 0;

    cla_seq_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vs);
        chk("issue_in_ready", {31'b0, in_ready}, 1);
        a = va; b = vb; cin = vc; op_sub = vs; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~vc; op_sub = ~vs;
    endtask

    task automatic await_result(input string tag, input logic [15:0] es, input logic ec, input logic ev);
        int n = 0;
        while (!out_valid && n < 20) begin
            chk({tag, "_busy"}, {31'b0, busy}, 1);
            step();
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_sum"}, {16'b0, sum}, {16'b0, es});
        chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, ev});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, {31'b0, out_valid}, 0);
        chk({tag, "_done_ready"}, {31'b0, in_ready}, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_sum", {16'b0, sum}, 0);
        chk("rst_cout_ovf", {30'b0, cout, ovf}, 0);

        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        await_result("t1", 16'h5555, 1'b0, 1'b0);
        release_out("t1");

        issue(16'h00FF, 16'h0000, 1'b1, 1'b0);
        await_result("t2a", 16'h0100, 1'b0, 1'b0);
        release_out("t2a");
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        await_result("t2b", 16'h0000, 1'b1, 1'b0);
        release_out("t2b");

        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        await_result("t3a", 16'h8000, 1'b0, 1'b1);
        release_out("t3a");
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        await_result("t3b", 16'h7FFF, 1'b1, 1'b1);
        release_out("t3b");

        issue(16'h0005, 16'h0007, 1'b1, 1'b1);
        await_result("t4", 16'hFFFE, 1'b0, 1'b0);

        a = 16'h0101; b = 16'h0202; cin = 1'b0; op_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            step();
            chk("t5_hold_valid", {31'b0, out_valid}, 1);
            chk("t5_hold_ready", {31'b0, in_ready}, 0);
            chk("t5_hold_sum", {16'b0, sum}, 32'hFFFE);
            chk("t5_hold_flags", {30'b0, cout, ovf}, 0);
        end
        in_valid = 1'b0;
        release_out("t5");
        step(); step();
        chk("t5_not_taken_valid", {31'b0, out_valid}, 0);
        chk("t5_not_taken_busy", {31'b0, busy}, 0);
        chk("t5_not_taken_sum", {16'b0, sum}, 32'hFFFE);

        issue(16'h1111, 16'h1111, 1'b0, 1'b0);
        step(); step();
        chk("t6_partial_busy", {31'b0, busy}, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_in_ready", {31'b0, in_ready}, 1);
        chk("t6_out_valid", {31'b0, out_valid}, 0);
        chk("t6_sum", {16'b0, sum}, 0);
        chk("t6_cout_ovf", {30'b0, cout, ovf}, 0);
        step(); step();
        chk("t6_no_emit", {31'b0, out_valid}, 0);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);
        await_result("t6b", 16'h0002, 1'b0, 1'b0);
        release_out("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
